filter_buffer_reader: RTL

//  Read-side sequencer for the 5x5 filter buffer. On start it walks filter indices
//  0..num_filters-1, issues one buffer read per filter and captures the 5x5 filter
//  (and its bias). It then presents each filter to the convolution engine over a

---
 rtl/filter_buffer_reader_if.sv | 35 +++
 rtl/filter_buffer_reader.sv | 125 ++++++++++++
 2 files changed

// File: rtl/filter_buffer_reader_if.sv
// Filter buffer read bus plus the filter presentation channel to the convolution engine.
// master = the reader sequencer, slave = the buffer/engine side.
interface filter_buffer_reader_if #(
  parameter int N  = 5,
  parameter int DW = 16
);
  logic                fb_read;
  logic [15:0]         fb_index_filter;
  logic [15:0]         fb_index_bias;
  logic [N*N*DW-1:0]   fb_filter;
  logic [DW-1:0]       fb_bias;

  // out_* transfer when out_valid & out_ready are both high on a rising edge;
  // out_* stay stable while out_valid=1 and out_ready=0, and out_valid never
  // drops without an acceptance.
  logic [N*N*DW-1:0]   out_filter;
  logic [DW-1:0]       out_bias;
  logic [15:0]         out_index;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output fb_read, fb_index_filter, fb_index_bias,
    input  fb_filter, fb_bias,
    output out_filter, out_bias, out_index, out_valid,
    input  out_ready
  );

  modport slave (
    input  fb_read, fb_index_filter, fb_index_bias,
    output fb_filter, fb_bias,
    input  out_filter, out_bias, out_index, out_valid,
    output out_ready
  );
endinterface

// File: rtl/filter_buffer_reader.sv
// Read-side sequencer for the NxN filter buffer: reads each filter, then presents it on a valid/ready channel.
// Optional macro FILTER_READER_BIAS_EN enables bias capture; otherwise bias index and out_bias are zero.
module filter_buffer_reader #(
  parameter int N           = 5,
  parameter int DW          = 16,
  parameter int MAX_FILTERS = 120,
  parameter int READ_LAT    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [15:0]            num_filters,
  filter_buffer_reader_if.master bus,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             fsm_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int          LW       = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(READ_LAT - 1);
  localparam logic [15:0] MAX_N    = 16'(MAX_FILTERS);

  state_t            state, state_next;
  logic [15:0]       n_q;
  logic [15:0]       idx_q;
  logic [15:0]       last_idx_q;
  logic [LW-1:0]     lat_q;
  logic [N*N*DW-1:0] filter_q;
  logic [DW-1:0]     bias_q;
  logic [15:0]       out_index_q;

  logic [15:0] n_clip;
  logic        lat_end;
  logic        accept;
  logic        last_filter;

  assign n_clip      = (num_filters > MAX_N) ? MAX_N : num_filters;
  assign lat_end     = (lat_q == LAT_LAST);
  assign accept      = (state == PRESENT) && bus.out_ready;
  assign last_filter = (idx_q == n_q - 16'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (n_clip == 16'd0) ? DONE : REQ;
      REQ:     state_next = WAIT;
      WAIT:    if (lat_end) state_next = PRESENT;
      PRESENT: if (accept) state_next = last_filter ? DONE : REQ;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q         <= '0;
      idx_q       <= '0;
      last_idx_q  <= '0;
      lat_q       <= '0;
      filter_q    <= '0;
      bias_q      <= '0;
      out_index_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_q   <= n_clip;
            idx_q <= '0;
          end
        end
        REQ: begin
          last_idx_q <= idx_q;
          lat_q      <= '0;
        end
        WAIT: begin
          if (lat_end) begin
            filter_q    <= bus.fb_filter;
            out_index_q <= idx_q;
`ifdef FILTER_READER_BIAS_EN
            bias_q      <= bus.fb_bias;
`endif
          end else begin
            lat_q <= lat_q + LW'(1);
          end
        end
        PRESENT: begin
          if (accept && !last_filter) idx_q <= idx_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // The read index is live only during REQ and holds the last issued value elsewhere.
  assign bus.fb_read         = (state == REQ);
  assign bus.fb_index_filter = (state == REQ) ? idx_q : last_idx_q;
`ifdef FILTER_READER_BIAS_EN
  assign bus.fb_index_bias   = bus.fb_index_filter;
`else
  assign bus.fb_index_bias   = '0;
`endif

  assign bus.out_filter = filter_q;
  assign bus.out_bias   = bias_q;
  assign bus.out_index  = out_index_q;
  assign bus.out_valid  = (state == PRESENT);

  assign busy      = (state == REQ) || (state == WAIT) || (state == PRESENT);
  assign done      = (state == DONE);
  assign fsm_state = state;

endmodule
